// File: rtl/demux_buffer.sv
// demux_buffer: byte-wide 1-to-2 stream demultiplexer with one FIFO per channel.
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset; clears pointers, counts and storage
//   in_data    input word
//   in_sel     target channel (0 -> out0, 1 -> out1)
//   in_valid   in_data/in_sel valid
//   in_ready   selected channel not full (ignores same-cycle pops)
//   outN_data  head entry of channel N
//   outN_valid channel N non-empty
//   outN_ready consumer N accepts
//   countN     entries held in channel N
// Optional (macro DEMUX_STATS_EN): xfer0/xfer1 per-channel pop counters, stall flag.
module demux_buffer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CW-1:0]    count0,
   output logic [CW-1:0]    count1
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0]      xfer0,
   output logic [15:0]      xfer1,
   output logic             stall
`endif
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [2][DEPTH];
   logic [AW-1:0]    r_wp  [2];
   logic [AW-1:0]    r_rp  [2];
   logic [CW-1:0]    r_cnt [2];
   logic [1:0]       w_push, w_pop, w_full;
   always_comb begin
      w_full   = {r_cnt[1] == CW'(DEPTH), r_cnt[0] == CW'(DEPTH)};
      in_ready = in_sel ? !w_full[1] : !w_full[0];
      w_push   = {in_valid && in_ready && in_sel, in_valid && in_ready && !in_sel};
      w_pop    = {out1_valid && out1_ready, out0_valid && out0_ready};
   end
   // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int ch = 0; ch < 2; ch++) begin
            for (int i = 0; i < DEPTH; i++) r_mem[ch][i] <= '0;
            r_wp[ch]  <= '0;
            r_rp[ch]  <= '0;
            r_cnt[ch] <= '0;
         end
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (w_push[ch]) begin
               r_mem[ch][r_wp[ch]] <= in_data;
               r_wp[ch]            <= r_wp[ch] + 1'b1;
            end
            if (w_pop[ch]) r_rp[ch] <= r_rp[ch] + 1'b1;
            r_cnt[ch] <= r_cnt[ch] + CW'(w_push[ch]) - CW'(w_pop[ch]);
         end
      end
   end
   assign out0_valid = r_cnt[0] != '0;
   assign out1_valid = r_cnt[1] != '0;
   assign out0_data  = r_mem[0][r_rp[0]];
   assign out1_data  = r_mem[1][r_rp[1]];
   assign count0     = r_cnt[0];
   assign count1     = r_cnt[1];
`ifdef DEMUX_STATS_EN
   logic [15:0] r_xfer [2];
   logic        r_stall;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_xfer[0] <= '0;
         r_xfer[1] <= '0;
         r_stall   <= 1'b0;
      end else begin
         for (int ch = 0; ch < 2; ch++) if (w_pop[ch]) r_xfer[ch] <= r_xfer[ch] + 16'd1;
         r_stall <= in_valid && !in_ready;
      end
   end
   assign xfer0 = r_xfer[0];
   assign xfer1 = r_xfer[1];
   assign stall = r_stall;
`endif
endmodule

// File: tb/tb_demux_buffer.sv
// tb_demux_buffer: scoreboard-based self-checking bench for demux_buffer.
module tb_demux_buffer;
   localparam int D = 4;
   logic       clk = 0, rst_n = 0;
   logic [7:0] in_data = 0;
   logic       in_sel = 0, in_valid = 0, in_ready;
   logic [7:0] out0_data, out1_data;
   logic       out0_valid, out1_valid;
   logic       out0_ready = 0, out1_ready = 0;
   logic [2:0] count0, count1;
`ifdef DEMUX_STATS_EN
   logic [15:0] xfer0, xfer1;
   logic        stall;
`endif
   demux_buffer #(.WIDTH(8), .DEPTH(D), .CW(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
      .in_ready(in_ready), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
      .count0(count0), .count1(count1)
`ifdef DEMUX_STATS_EN
      , .xfer0(xfer0), .xfer1(xfer1), .stall(stall)
`endif
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int m0 = 0, m1 = 0;
   logic [7:0] q0[$], q1[$];

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset;
      m0 = 0; m1 = 0;
      q0.delete(); q1.delete();
   endtask

   // Drives one push attempt; the scoreboard takes the byte only if the model says there is room.
   task automatic do_push(input logic ch, input logic [7:0] d, output logic rdy);
      in_sel = ch; in_data = d; in_valid = 1;
      #1;
      rdy = in_ready;
      step();
      in_valid = 0;
      if (ch && m1 != D) begin q1.push_back(d); m1++; end
      if (!ch && m0 != D) begin q0.push_back(d); m0++; end
   endtask

   task automatic do_pop(input logic ch, output logic v, output logic [7:0] d);
      if (ch) out1_ready = 1; else out0_ready = 1;
      v = ch ? out1_valid : out0_valid;
      d = ch ? out1_data : out0_data;
      step();
      out0_ready = 0; out1_ready = 0;
      if (ch && m1 != 0) m1--;
      if (!ch && m0 != 0) m0--;
   endtask

   task automatic test_reset;
      rst_n = 0; in_valid = 1; in_data = 8'hFF; in_sel = 0;
      step(); step();
      rst_n = 1; in_valid = 0; in_data = 0;
      model_reset();
      tests++; if (count0 !== 3'd0) begin fails++; $display("FAIL reset_count0: got %0d want 0", count0); end
      tests++; if (count1 !== 3'd0) begin fails++; $display("FAIL reset_count1: got %0d want 0", count1); end
      tests++; if (out0_valid !== 1'b0) begin fails++; $display("FAIL reset_valid0: got %b want 0", out0_valid); end
      tests++; if (out1_valid !== 1'b0) begin fails++; $display("FAIL reset_valid1: got %b want 0", out1_valid); end
      tests++; if (out0_data !== 8'h00) begin fails++; $display("FAIL reset_data0: got %h want 00", out0_data); end
      tests++; if (out1_data !== 8'h00) begin fails++; $display("FAIL reset_data1: got %h want 00", out1_data); end
   endtask

   task automatic test_steering;
      logic r, v; logic [7:0] d, e;
      do_push(0, 8'h95, r);
      tests++; if (r !== 1'b1) begin fails++; $display("FAIL steer_ready0: got %b want 1", r); end
      tests++; if (out0_valid !== 1'b1) begin fails++; $display("FAIL steer_valid0: got %b want 1", out0_valid); end
      tests++; if (out1_valid !== 1'b0) begin fails++; $display("FAIL steer_valid1_idle: got %b want 0", out1_valid); end
      do_push(1, 8'hBF, r);
      tests++; if (out1_valid !== 1'b1) begin fails++; $display("FAIL steer_valid1: got %b want 1", out1_valid); end
      tests++; if (out0_data !== q0[0]) begin fails++; $display("FAIL steer_data0: got %h want %h", out0_data, q0[0]); end
      tests++; if (out1_data !== q1[0]) begin fails++; $display("FAIL steer_data1: got %h want %h", out1_data, q1[0]); end
      tests++; if (count0 !== 3'(m0) || count1 !== 3'(m1)) begin fails++; $display("FAIL steer_counts: got %0d/%0d want %0d/%0d", count0, count1, m0, m1); end
      for (int ch = 0; ch < 2; ch++) begin
         e = ch ? q1.pop_front() : q0.pop_front();
         do_pop(ch[0], v, d);
         tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL steer_drain%0d: got v=%b %h want v=1 %h", ch, v, d, e); end
      end
   endtask

   task automatic test_full;
      logic r, v; logic [7:0] d, e;
      for (int i = 1; i <= D; i++) do_push(0, 8'(i), r);
      tests++; if (count0 !== 3'd4) begin fails++; $display("FAIL full_count0: got %0d want 4", count0); end
      in_sel = 0; #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_sel0: got %b want 0", in_ready); end
      do_push(0, 8'h77, r);
      tests++; if (r !== 1'b0 || count0 !== 3'd4) begin fails++; $display("FAIL full_reject: got rdy=%b cnt=%0d want rdy=0 cnt=4", r, count0); end
`ifdef DEMUX_STATS_EN
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL full_stall: got %b want 1", stall); end
`endif
      in_sel = 1; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_sel1: got %b want 1", in_ready); end
      do_push(1, 8'hAA, r);
      tests++; if (count1 !== 3'(m1) || out1_data !== 8'hAA) begin fails++; $display("FAIL full_ch1_push: got cnt=%0d %h want cnt=%0d aa", count1, out1_data, m1); end
      e = q1.pop_front();
      do_pop(1, v, d);
      tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL full_ch1_drain: got v=%b %h want v=1 %h", v, d, e); end
   endtask

   task automatic test_wrap;
      logic r, v; logic [7:0] d, e;
      for (int i = 0; i < 2; i++) begin
         e = q0.pop_front();
         do_pop(0, v, d);
         tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL wrap_pop%0d: got v=%b %h want v=1 %h", i, v, d, e); end
      end
      do_push(0, 8'h05, r);
      do_push(0, 8'h06, r);
      tests++; if (count0 !== 3'(m0)) begin fails++; $display("FAIL wrap_count: got %0d want %0d", count0, m0); end
      for (int i = 0; i < D; i++) begin
         e = q0.pop_front();
         do_pop(0, v, d);
         tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL wrap_drain%0d: got v=%b %h want v=1 %h", i, v, d, e); end
      end
      tests++; if (out0_valid !== 1'b0 || count0 !== 3'd0) begin fails++; $display("FAIL wrap_empty: got v=%b cnt=%0d want 0/0", out0_valid, count0); end
      do_pop(0, v, d);
      tests++; if (count0 !== 3'd0) begin fails++; $display("FAIL empty_pop: got %0d want 0", count0); end
   endtask

   task automatic test_back_to_back;
      logic r, v; logic [7:0] d, e;
      do_push(1, 8'h10, r);
      do_push(1, 8'h11, r);
      in_sel = 1; in_data = 8'h12; in_valid = 1; out1_ready = 1;
      #1;
      d = out1_data;
      step();
      in_valid = 0; out1_ready = 0;
      e = q1.pop_front();
      q1.push_back(8'h12);
      tests++; if (d !== e) begin fails++; $display("FAIL simul_popdata: got %h want %h", d, e); end
      tests++; if (count1 !== 3'd2) begin fails++; $display("FAIL simul_count1: got %0d want 2", count1); end
      while (q1.size() != 0) begin
         e = q1.pop_front();
         do_pop(1, v, d);
         tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL simul_drain: got v=%b %h want v=1 %h", v, d, e); end
      end
   endtask

   task automatic test_midreset;
      logic r, v; logic [7:0] d, e;
      for (int i = 0; i < 3; i++) do_push(0, 8'hC0 + 8'(i), r);
      tests++; if (count0 !== 3'd3) begin fails++; $display("FAIL mid_pre_count: got %0d want 3", count0); end
      rst_n = 0;
      step();
      rst_n = 1;
      model_reset();
      tests++; if (count0 !== 3'd0 || out0_valid !== 1'b0) begin fails++; $display("FAIL mid_reset: got cnt=%0d v=%b want 0/0", count0, out0_valid); end
      tests++; if (out0_data !== 8'h00) begin fails++; $display("FAIL mid_reset_data: got %h want 00", out0_data); end
`ifdef DEMUX_STATS_EN
      tests++; if (xfer0 !== 16'd0) begin fails++; $display("FAIL mid_xfer0_reset: got %0d want 0", xfer0); end
`endif
      do_push(0, 8'h5A, r);
      e = q0.pop_front();
      do_pop(0, v, d);
      tests++; if (v !== 1'b1 || d !== e) begin fails++; $display("FAIL mid_after: got v=%b %h want v=1 %h", v, d, e); end
`ifdef DEMUX_STATS_EN
      tests++; if (xfer0 !== 16'd1) begin fails++; $display("FAIL mid_xfer0_inc: got %0d want 1", xfer0); end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_steering();
      test_full();
      test_wrap();
      test_back_to_back();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/demux_buffer.md
Name: demux_buffer

Overview:
- Byte-wide 1-to-2 stream demultiplexer; the inverse of the 8-bit 2:1 mux array.
- Each input byte is steered by in_sel to channel 0 or channel 1.
- Each channel has its own FIFO and its own valid/ready output handshake.
- Sits between a single byte producer and two independent consumers (e.g. split datapath lanes).

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, entries per channel FIFO; power of 2, at least 2.
- CW, 3, count width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_data  input  WIDTH  input byte
- in_sel  input  1  target channel (0 -> out0, 1 -> out1)
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  selected channel can accept
- out0_data  output  WIDTH  channel 0 head entry
- out0_valid  output  1  channel 0 non-empty
- out0_ready  input  1  consumer 0 accepts
- out1_data  output  WIDTH  channel 1 head entry
- out1_valid  output  1  channel 1 non-empty
- out1_ready  input  1  consumer 1 accepts
- count0  output  CW  entries held in channel 0
- count1  output  CW  entries held in channel 1

Behaviour:
- Single clock domain.
- Reset: rst_n is synchronous and active-low, sampled on the rising edge of clk. On a reset edge:
  - all read/write pointers and counts go to 0;
  - FIFO storage is cleared to 0;
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0, count0 = count1 = 0.
- in_ready is combinational: in_ready = (in_sel ? count1 != DEPTH : count0 != DEPTH).
  - It depends on in_sel, never on in_valid.
  - It does not consider a same-cycle pop: a full channel stays not-ready even if its consumer pops that cycle.
- Push to channel c occurs when in_valid && in_ready && in_sel == c at a clock edge:
  - write data to the write-pointer location;
  - write pointer increments modulo DEPTH (wraps DEPTH-1 -> 0).
- Pop from channel c occurs when outc_valid && outc_ready at a clock edge:
  - read pointer increments modulo DEPTH.
- outc_valid = (countc != 0); outc_data = storage[read pointer]. Both are derived from registers, with no combinational path from in_*.
- Latency: a byte pushed at edge k is visible at the output from edge k onward (valid one cycle after acceptance). There is no same-cycle bypass.
- Same-cycle push and pop on one channel (not full): count unchanged, both pointers advance. On an empty channel, a push and no pop gives count = 1.
- Pop with outc_ready while empty: ignored, no pointer or count change.
- The channels are fully independent. Pushing to channel 0 while channel 1 pops is legal in the same cycle.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee across channels.
- Reset mid-operation: all contents are discarded, and no valid is asserted in the cycle after the reset edge.
- Consumer handshake rule: outc_data stays stable while outc_valid is 1 and outc_ready is 0.
- Producer handshake rule: the producer must hold in_data/in_sel while in_valid is 1 and in_ready is 0. Changing in_sel while stalled is legal, but re-evaluates in_ready.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - adds outputs xfer0 and xfer1, each 16 bits;
  - each counts completed pops on its channel;
  - counters wrap at 16'hFFFF -> 0 and reset to 0 on rst_n.
  - adds output stall, 1 bit, registered: 1 for the cycle after any edge where in_valid=1 and in_ready=0.
- Undefined: these ports and their logic do not exist; behaviour is otherwise identical.

Test Plan:
- Reset check: hold rst_n=0 for 2 edges with in_valid=1, in_data=8'hFF -> after release, count0=count1=0, out0_valid=out1_valid=0, out0_data=out1_data=8'h00.
- Steering: push 8'h95 sel=0, then 8'hBF sel=1, both consumers not ready -> out0_data=8'h95, out1_data=8'hBF, count0=count1=1, each valid one cycle after its push.
- Full/backpressure: push 8'h01..8'h04 to channel 0 with out0_ready=0 -> count0=4 and in_ready=0 for sel=0. Then switch to sel=1 -> in_ready=1 and a push of 8'hAA lands in channel 1.
- Wrap-around: with channel 0 full, drain 2 (8'h01, 8'h02), push 8'h05 and 8'h06, then drain all -> sequence 8'h03, 8'h04, 8'h05, 8'h06 in order, with pointers wrapped.
- Simultaneous push and pop on channel 1 at count1=2 -> count1 stays 2; popped value equals the oldest entry.
- Mid-stream reset: assert rst_n=0 at count0=3 -> next cycle count0=0 and out0_valid=0. With DEMUX_STATS_EN, xfer0=0 after reset and increments by 1 per pop.
